game_turn_controller: RTL and testbench

//  Sequences one tic-tac-toe game. Owns the nine 2-bit position registers and alternates turns P1 -> P2.

---
 rtl/game_turn_controller.sv | 175 +++++++++++++++++
 tb/tb_game_turn_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_turn_controller.sv
// Tic-tac-toe turn sequencer: owns the board, screens and commits moves,
// alternates players, enforces an idle timeout and reports win/draw.
module game_turn_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned TMR_W          = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       new_game,
  input  logic       play,
  input  logic       player2,
  input  logic [3:0] pos_sel,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic       turn,
  output logic       illegal_move,
  output logic       timeout,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [3:0] move_count,
  output logic [3:0] illegal_count
);

  typedef enum logic [1:0] {
    StWaitP1,
    StWaitP2,
    StEval,
    StGameOver
  } state_e;

  localparam logic             TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [TMR_W-1:0] TimerLast = TMR_W'(TIMEOUT_CYCLES - 32'd1);

  state_e           state_q;
  logic [1:0]       board_q [9];
  logic [TMR_W-1:0] timer_q;

  logic       waiting;
  logic       request;
  logic       on_turn;
  logic       sel_ok;
  logic       sq_empty;
  logic       legal;
  logic       expired;
  logic [1:0] mover_code;
  logic [1:0] eval_mark;
  logic [8:0] owned;
  logic       line_win;

  always_comb begin
    waiting    = (state_q == StWaitP1) || (state_q == StWaitP2);
    request    = waiting && (play || player2);
    on_turn    = (state_q == StWaitP1) ? play : player2;
    sel_ok     = (pos_sel >= 4'd1) && (pos_sel <= 4'd9);
    sq_empty   = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (pos_sel == 4'(i + 1)) begin
        sq_empty = (board_q[i] == 2'b00);
      end
    end
    legal      = waiting && (play ^ player2) && on_turn && sel_ok && sq_empty;
    expired    = TimeoutEn && (timer_q == TimerLast);
    mover_code = (state_q == StWaitP2) ? 2'b10 : 2'b01;
  end

  // In EVAL the turn register still names the player who just moved.
  always_comb begin
    eval_mark = turn ? 2'b10 : 2'b01;
    for (int i = 0; i < 9; i++) begin
      owned[i] = (board_q[i] == eval_mark);
    end
    line_win = (owned[0] & owned[1] & owned[2]) |
               (owned[3] & owned[4] & owned[5]) |
               (owned[6] & owned[7] & owned[8]) |
               (owned[0] & owned[3] & owned[6]) |
               (owned[1] & owned[4] & owned[7]) |
               (owned[2] & owned[5] & owned[8]) |
               (owned[0] & owned[4] & owned[8]) |
               (owned[2] & owned[4] & owned[6]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StWaitP1;
      for (int i = 0; i < 9; i++) board_q[i] <= 2'b00;
      timer_q       <= '0;
      turn          <= 1'b0;
      illegal_move  <= 1'b0;
      timeout       <= 1'b0;
      game_over     <= 1'b0;
      winner        <= 2'b00;
      move_count    <= 4'd0;
      illegal_count <= 4'd0;
    end else begin
      illegal_move <= 1'b0;
      timeout      <= 1'b0;
      if (new_game) begin
        state_q       <= StWaitP1;
        for (int i = 0; i < 9; i++) board_q[i] <= 2'b00;
        timer_q       <= '0;
        turn          <= 1'b0;
        game_over     <= 1'b0;
        winner        <= 2'b00;
        move_count    <= 4'd0;
        illegal_count <= 4'd0;
      end else begin
        unique case (state_q)
          StWaitP1, StWaitP2: begin
            if (legal) begin
              for (int i = 0; i < 9; i++) begin
                if (pos_sel == 4'(i + 1)) board_q[i] <= mover_code;
              end
              move_count <= move_count + 4'd1;
              timer_q    <= '0;
              state_q    <= StEval;
            end else begin
              if (request) begin
                illegal_move <= 1'b1;
                if (illegal_count != 4'hF) illegal_count <= illegal_count + 4'd1;
              end
              if (TimeoutEn) begin
                if (expired) begin
                  state_q <= (state_q == StWaitP1) ? StWaitP2 : StWaitP1;
                  turn    <= (state_q == StWaitP1);
                  timer_q <= '0;
                  timeout <= 1'b1;
                end else begin
                  timer_q <= timer_q + 1'b1;
                end
              end
            end
          end
          StEval: begin
            if (line_win) begin
              state_q   <= StGameOver;
              game_over <= 1'b1;
              winner    <= eval_mark;
              turn      <= 1'b0;
            end else if (move_count == 4'd9) begin
              state_q   <= StGameOver;
              game_over <= 1'b1;
              winner    <= 2'b11;
              turn      <= 1'b0;
            end else begin
              state_q <= turn ? StWaitP1 : StWaitP2;
              turn    <= ~turn;
              timer_q <= '0;
            end
          end
          StGameOver: begin
          end
          default: state_q <= StWaitP1;
        endcase
      end
    end
  end

  assign pos1 = board_q[0];
  assign pos2 = board_q[1];
  assign pos3 = board_q[2];
  assign pos4 = board_q[3];
  assign pos5 = board_q[4];
  assign pos6 = board_q[5];
  assign pos7 = board_q[6];
  assign pos8 = board_q[7];
  assign pos9 = board_q[8];

endmodule

// File: tb/tb_game_turn_controller.sv
// Directed and randomized bench for game_turn_controller against a
// rule-level game model.
module tb_game_turn_controller;

  localparam int unsigned Tmo = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       new_game = 1'b0;
  logic       play = 1'b0;
  logic       player2 = 1'b0;
  logic [3:0] pos_sel = 4'd0;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic       turn, illegal_move, timeout, game_over;
  logic [1:0] winner;
  logic [3:0] move_count, illegal_count;
  logic [1:0] dpos [9];

  int checks = 0;
  int failures = 0;

  game_turn_controller #(.TIMEOUT_CYCLES(Tmo), .TMR_W(16)) dut (
    .clock(clock), .reset(reset), .new_game(new_game), .play(play), .player2(player2),
    .pos_sel(pos_sel), .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
    .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9), .turn(turn),
    .illegal_move(illegal_move), .timeout(timeout), .game_over(game_over), .winner(winner),
    .move_count(move_count), .illegal_count(illegal_count)
  );

  always #5 clock = ~clock;

  assign dpos[0] = pos1;
  assign dpos[1] = pos2;
  assign dpos[2] = pos3;
  assign dpos[3] = pos4;
  assign dpos[4] = pos5;
  assign dpos[5] = pos6;
  assign dpos[6] = pos7;
  assign dpos[7] = pos8;
  assign dpos[8] = pos9;

  // Game model: who owns each square, whose move it is, and what phase the game is in.
  int brd [9];
  int phase;   // 0 waiting for a move, 1 judging the last move, 2 finished
  int mover;   // 1 or 2: player to move, or player who just moved while judging
  int tmr, win, mc, ic;
  bit ill_p, to_p;
  int lines [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                       '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};

  function automatic void model_clear();
    for (int i = 0; i < 9; i++) brd[i] = 0;
    phase = 0; mover = 1; tmr = 0; win = 0; mc = 0; ic = 0; ill_p = 0; to_p = 0;
  endfunction

  function automatic bit has_line(int p);
    for (int l = 0; l < 8; l++)
      if (brd[lines[l][0]] == p && brd[lines[l][1]] == p && brd[lines[l][2]] == p) return 1;
    return 0;
  endfunction

  function automatic void model_step(bit ng, bit p1, bit p2, int sel);
    bit ok;
    ill_p = 0;
    to_p = 0;
    if (ng) begin
      model_clear();
      return;
    end
    if (phase == 0) begin
      ok = (p1 != p2) && ((mover == 1) ? p1 : p2) && sel >= 1 && sel <= 9;
      if (ok) ok = (brd[sel-1] == 0);
      if (ok) begin
        brd[sel-1] = mover;
        mc++;
        phase = 1;
        tmr = 0;
      end else begin
        if (p1 || p2) begin
          ill_p = 1;
          if (ic < 15) ic++;
        end
        if (Tmo != 0) begin
          if (tmr == Tmo - 1) begin
            mover = 3 - mover;
            tmr = 0;
            to_p = 1;
          end else tmr++;
        end
      end
    end else if (phase == 1) begin
      if (has_line(mover)) begin
        phase = 2; win = mover;
      end else if (mc == 9) begin
        phase = 2; win = 3;
      end else begin
        mover = 3 - mover; phase = 0; tmr = 0;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string ctx);
    for (int i = 0; i < 9; i++) check($sformatf("%s.pos%0d", ctx, i + 1), 32'(dpos[i]), brd[i]);
    check({ctx, ".turn"}, 32'(turn), (phase != 2 && mover == 2) ? 1 : 0);
    check({ctx, ".illegal_move"}, 32'(illegal_move), 32'(ill_p));
    check({ctx, ".timeout"}, 32'(timeout), 32'(to_p));
    check({ctx, ".game_over"}, 32'(game_over), (phase == 2) ? 1 : 0);
    check({ctx, ".winner"}, 32'(winner), win);
    check({ctx, ".move_count"}, 32'(move_count), mc);
    check({ctx, ".illegal_count"}, 32'(illegal_count), ic);
  endtask

  task automatic cyc(input string ctx, input bit ng, input bit p1, input bit p2, input int sel);
    @(negedge clock);
    new_game = ng; play = p1; player2 = p2; pos_sel = 4'(sel);
    model_step(ng, p1, p2, sel);
    @(posedge clock);
    #1;
    new_game = 0; play = 0; player2 = 0;
    compare_all(ctx);
  endtask

  task automatic move(input string ctx, input int p, input int sel);
    cyc(ctx, 0, p == 1, p == 2, sel);
    cyc({ctx, ".eval"}, 0, 0, 0, 0);
  endtask

  int p1s [5];
  int p2s [4];

  initial begin
    model_clear();
    #12;
    compare_all("reset");
    @(negedge clock);
    reset = 1;

    // First move and evaluation latency.
    cyc("p1_5", 0, 1, 0, 5);
    check("p1_5.pos5_n1", 32'(pos5), 1);
    check("p1_5.turn_eval", 32'(turn), 0);
    cyc("p1_5.eval", 0, 0, 0, 0);
    check("p1_5.turn_n2", 32'(turn), 1);
    check("p1_5.mc", 32'(move_count), 1);
    cyc("p2_occupied", 0, 0, 1, 5);
    check("occ.illegal", 32'(illegal_move), 1);
    check("occ.ic", 32'(illegal_count), 1);
    cyc("occ.after", 0, 0, 0, 0);

    // Wrong turn, both buttons, out-of-range squares.
    cyc("ng1", 1, 1, 0, 3);
    cyc("wrong_turn", 0, 0, 1, 1);
    cyc("both", 0, 1, 1, 2);
    cyc("sel0", 0, 1, 0, 0);
    cyc("sel12", 0, 1, 0, 12);
    check("range.ic", 32'(illegal_count), 4);
    cyc("range.idle", 0, 0, 0, 0);

    // P1 wins on the top row; later strobes ignored.
    cyc("ng2", 1, 0, 0, 0);
    move("w1", 1, 1); move("w2", 2, 4); move("w3", 1, 2); move("w4", 2, 5); move("w5", 1, 3);
    check("win.winner", 32'(winner), 1);
    check("win.mc", 32'(move_count), 5);
    cyc("win.ign1", 0, 0, 1, 9);
    cyc("win.ign2", 0, 1, 0, 7);
    check("win.ic_held", 32'(illegal_count), 0);

    // Full-board draw.
    cyc("ng3", 1, 0, 0, 0);
    p1s = '{1, 3, 4, 8, 9};
    p2s = '{2, 5, 6, 7};
    for (int k = 0; k < 9; k++)
      move($sformatf("draw%0d", k), (k % 2) + 1, (k % 2 == 0) ? p1s[k/2] : p2s[k/2]);
    check("draw.winner", 32'(winner), 3);
    check("draw.mc", 32'(move_count), 9);

    // Ninth move completes a line: mover wins.
    cyc("ng4", 1, 0, 0, 0);
    p1s = '{1, 6, 7, 8, 9};
    p2s = '{2, 3, 4, 5};
    for (int k = 0; k < 9; k++)
      move($sformatf("late%0d", k), (k % 2) + 1, (k % 2 == 0) ? p1s[k/2] : p2s[k/2]);
    check("late.winner", 32'(winner), 1);

    // Idle timeout.
    cyc("ng5", 1, 0, 0, 0);
    for (int k = 0; k < int'(Tmo); k++) cyc($sformatf("idle%0d", k), 0, 0, 0, 0);
    check("tmo.pulse", 32'(timeout), 1);
    check("tmo.turn", 32'(turn), 1);
    check("tmo.mc", 32'(move_count), 0);
    move("tmo.p2", 2, 7);
    cyc("ng_mid", 1, 0, 0, 0);
    check("ng_mid.pos7", 32'(pos7), 0);

    // Asynchronous reset while judging a move.
    cyc("pre_rst", 0, 1, 0, 4);
    #2;
    reset = 0;
    #1;
    model_clear();
    compare_all("rst_eval");
    @(negedge clock);
    reset = 1;

    // Randomized play against the model.
    for (int n = 0; n < 3000; n++) begin
      int s, sel;
      bit ng;
      ng = ($urandom_range(0, 199) == 0) || (phase == 2 && $urandom_range(0, 5) == 0);
      s = $urandom_range(0, 11);
      sel = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 9);
      cyc("rand", ng, (s < 3) || (s == 6), (s >= 3 && s < 6) || (s == 6), sel);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
